// File: rtl/led_p2s_pkg.sv
// Shared types and sizing helpers for the LED parallel-to-serial controller.
// Counter widths depend on instance parameters, so they come from functions here.
package led_p2s_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    LO,
    HI,
    DONE
  } state_t;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_DIV   = 4;

  // Bit counter must hold WIDTH itself, hence WIDTH+1 codes.
  function automatic int bit_cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

  // Divider counts 0..DIV-1; keep at least one bit for DIV=1.
  function automatic int div_cnt_width(input int div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

  localparam int DEF_BIT_CNT_W = bit_cnt_width(DEF_WIDTH);
  localparam int DEF_DIV_CNT_W = div_cnt_width(DEF_DIV);

endpackage

// File: rtl/led_p2s_div.sv
// Phase divider: tick marks the last clk cycle of each DIV-cycle serial-clock phase.
// Synchronous clear restarts the phase count at a frame boundary.
module led_p2s_div
  import led_p2s_pkg::*;
#(
  parameter int DIV = DEF_DIV
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CNT_W = div_cnt_width(DIV);

  logic [CNT_W-1:0] cnt;

  assign tick = en && (cnt == CNT_W'(DIV - 1));

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/led_p2s_ctrl.sv
// LED chain parallel-to-serial controller: shifts a WIDTH-bit frame out on led_do/led_clk.
// Optional feature macro LED_P2S_CLR_EN adds a chain-clear (CLR) phase before each frame.
module led_p2s_ctrl
  import led_p2s_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int DIV       = DEF_DIV,
  parameter int MSB_FIRST = 1,
  parameter int DO_INV    = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] p_in,
  output logic             busy,
  output logic             done,
  output logic             led_do,
  output logic             led_clk,
  output logic             led_clr_n
);

  localparam int   BIT_CNT_W = bit_cnt_width(WIDTH);
  localparam logic IDLE_DO   = (DO_INV != 0);

  state_t               state;
  logic [WIDTH-1:0]     sr;
  logic [WIDTH-1:0]     sr_next;
  logic [BIT_CNT_W-1:0] bit_cnt;
  logic                 accept;
  logic                 tick;

  // Line level for the bit currently at the output end of a frame word.
  function automatic logic out_bit(input logic [WIDTH-1:0] v);
    return ((MSB_FIRST != 0) ? v[WIDTH-1] : v[0]) ^ IDLE_DO;
  endfunction

  assign sr_next = (MSB_FIRST != 0) ? {sr[WIDTH-2:0], 1'b0} : {1'b0, sr[WIDTH-1:1]};

  // busy is low exactly in IDLE and DONE, the only states that take a new frame.
  assign accept = start && !busy;

  led_p2s_div #(
    .DIV (DIV)
  ) u_div (
    .clk  (clk),
    .rst  (rst),
    .clr  (accept),
    .en   (busy),
    .tick (tick)
  );

`ifdef LED_P2S_CLR_EN
  logic clr_n_q;
  assign led_clr_n = clr_n_q;
`else
  assign led_clr_n = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      sr      <= '0;
      bit_cnt <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      led_clk <= 1'b1;
      led_do  <= IDLE_DO;
`ifdef LED_P2S_CLR_EN
      clr_n_q <= 1'b1;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            sr      <= p_in;
            bit_cnt <= BIT_CNT_W'(WIDTH);
            busy    <= 1'b1;
`ifdef LED_P2S_CLR_EN
            state   <= CLR;
            clr_n_q <= 1'b0;
            led_clk <= 1'b1;
            led_do  <= IDLE_DO;
`else
            state   <= LO;
            led_clk <= 1'b0;
            led_do  <= out_bit(p_in);
`endif
          end else begin
            state   <= IDLE;
            busy    <= 1'b0;
            led_clk <= 1'b1;
            led_do  <= IDLE_DO;
          end
        end
`ifdef LED_P2S_CLR_EN
        CLR: begin
          if (tick) begin
            state   <= LO;
            clr_n_q <= 1'b1;
            led_clk <= 1'b0;
            led_do  <= out_bit(sr);
          end
        end
`endif
        LO: begin
          if (tick) begin
            state   <= HI;
            led_clk <= 1'b1;
          end
        end
        HI: begin
          // The chain has sampled led_do on this phase's rising edge; advance now.
          if (tick) begin
            sr      <= sr_next;
            bit_cnt <= bit_cnt - BIT_CNT_W'(1);
            if (bit_cnt > BIT_CNT_W'(1)) begin
              state   <= LO;
              led_clk <= 1'b0;
              led_do  <= out_bit(sr_next);
            end else begin
              state  <= DONE;
              busy   <= 1'b0;
              done   <= 1'b1;
              led_do <= IDLE_DO;
            end
          end
        end
        default: begin
          state   <= IDLE;
          busy    <= 1'b0;
          led_clk <= 1'b1;
          led_do  <= IDLE_DO;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_led_p2s_ctrl.sv
// Scoreboard bench for led_p2s_ctrl: expected bits and done cycles are queued at start
// and retired by per-instance monitors on each led_clk rise and done pulse.
module tb_led_p2s_ctrl;

`ifdef LED_P2S_CLR_EN
  localparam int CLR_ON = 1;
`else
  localparam int CLR_ON = 0;
`endif

  localparam int DIV_AB = 2;
  localparam int W_AB   = 16;
  localparam int CLRC_A = CLR_ON * DIV_AB;
  localparam int LAT_A  = 2 * DIV_AB * W_AB + 1 + CLRC_A;
  localparam int CLRC_C = CLR_ON * 1;
  localparam int LAT_C  = 2 * 1 * 2 + 1 + CLRC_C;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        start_c;
  logic [15:0] p_in;
  logic [1:0]  p_in_c;

  logic busy_a, done_a, led_do_a, led_clk_a, led_clr_n_a;
  logic busy_b, done_b, led_do_b, led_clk_b, led_clr_n_b;
  logic busy_c, done_c, led_do_c, led_clk_c, led_clr_n_c;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  logic q_a[$];
  logic q_b[$];
  logic q_c[$];
  int   dq_a[$];
  int   dq_b[$];
  int   dq_c[$];

  logic        prev_a, prev_b, prev_c;
  logic [15:0] obs_a, obs_b;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  led_p2s_ctrl #(.WIDTH(16), .DIV(2), .MSB_FIRST(1), .DO_INV(1)) dut_a (
    .clk(clk), .rst(rst), .start(start), .p_in(p_in), .busy(busy_a), .done(done_a),
    .led_do(led_do_a), .led_clk(led_clk_a), .led_clr_n(led_clr_n_a));

  led_p2s_ctrl #(.WIDTH(16), .DIV(2), .MSB_FIRST(0), .DO_INV(0)) dut_b (
    .clk(clk), .rst(rst), .start(start), .p_in(p_in), .busy(busy_b), .done(done_b),
    .led_do(led_do_b), .led_clk(led_clk_b), .led_clr_n(led_clr_n_b));

  led_p2s_ctrl #(.WIDTH(2), .DIV(1), .MSB_FIRST(1), .DO_INV(1)) dut_c (
    .clk(clk), .rst(rst), .start(start_c), .p_in(p_in_c), .busy(busy_c), .done(done_c),
    .led_do(led_do_c), .led_clk(led_clk_c), .led_clr_n(led_clr_n_c));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference serial-clock level at cycle r after acceptance.
  function automatic logic exp_clk(input int r, input int div, input int w, input int clrc);
    if (r <= clrc || r > clrc + 2 * div * w) return 1'b1;
    return (((r - clrc - 1) / div) % 2) == 1;
  endfunction

  function automatic logic exp_busy(input int r, input int div, input int w, input int clrc);
    return (r >= 1) && (r <= clrc + 2 * div * w);
  endfunction

  task automatic push_ab(input logic [15:0] v, input int s);
    for (int i = 0; i < 16; i++) begin
      q_a.push_back(v[15-i] ^ 1'b1);
      q_b.push_back(v[i]);
    end
    dq_a.push_back(s + LAT_A);
    dq_b.push_back(s + LAT_A);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Monitors: retire one expected bit per led_clk rise, one expected cycle per done.
  always @(negedge clk) begin
    if (busy_a === 1'b1 && led_clk_a === 1'b1 && prev_a === 1'b0) begin
      check("a_bitq", 64'(q_a.size() != 0), 1);
      if (q_a.size() != 0) check("a_bit", led_do_a, q_a.pop_front());
      obs_a <= {obs_a[14:0], led_do_a};
    end
    if (done_a === 1'b1) begin
      check("a_doneq", 64'(dq_a.size() != 0), 1);
      if (dq_a.size() != 0) check("a_done_cyc", cyc, dq_a.pop_front());
    end
    prev_a <= led_clk_a;
  end

  always @(negedge clk) begin
    if (busy_b === 1'b1 && led_clk_b === 1'b1 && prev_b === 1'b0) begin
      check("b_bitq", 64'(q_b.size() != 0), 1);
      if (q_b.size() != 0) check("b_bit", led_do_b, q_b.pop_front());
      obs_b <= {obs_b[14:0], led_do_b};
    end
    if (done_b === 1'b1) begin
      check("b_doneq", 64'(dq_b.size() != 0), 1);
      if (dq_b.size() != 0) check("b_done_cyc", cyc, dq_b.pop_front());
    end
    prev_b <= led_clk_b;
  end

  always @(negedge clk) begin
    if (busy_c === 1'b1 && led_clk_c === 1'b1 && prev_c === 1'b0) begin
      check("c_bitq", 64'(q_c.size() != 0), 1);
      if (q_c.size() != 0) check("c_bit", led_do_c, q_c.pop_front());
    end
    if (done_c === 1'b1) begin
      check("c_doneq", 64'(dq_c.size() != 0), 1);
      if (dq_c.size() != 0) check("c_done_cyc", cyc, dq_c.pop_front());
    end
    prev_c <= led_clk_c;
  end

  initial begin
    int s;
    int r;
    rst     = 1'b1;
    start   = 1'b1;
    start_c = 1'b1;
    p_in    = 16'hFFFF;
    p_in_c  = 2'b11;

    // Reset held with start high: start must be dropped.
    repeat (3) @(posedge clk);
    #1;
    rst     = 1'b0;
    start   = 1'b0;
    start_c = 1'b0;
    @(negedge clk);
    check("rst_busy_a", busy_a, 0);
    check("rst_busy_c", busy_c, 0);
    check("rst_done_a", done_a, 0);
    check("rst_clk_a", led_clk_a, 1);
    check("rst_do_a", led_do_a, 1);
    check("rst_do_b", led_do_b, 0);
    check("rst_clrn_a", led_clr_n_a, 1);

    // Two back-to-back frames: a stray start mid-frame and a restart in the DONE cycle.
    next_cycle();
    p_in  = 16'hA5C3;
    start = 1'b1;
    s     = cyc;
    push_ab(p_in, s);
    for (int c = 1; c <= 2 * LAT_A + 1; c++) begin
      next_cycle();
      start = 1'b0;
      if (c == 20) begin
        start = 1'b1;
        p_in  = 16'hFFFF;
      end
      if (c == LAT_A) begin
        start = 1'b1;
        p_in  = 16'h1234;
        push_ab(p_in, cyc);
      end
      r = (c <= LAT_A) ? c : c - LAT_A;
      @(negedge clk);
      check("f_busy_a", busy_a, exp_busy(r, DIV_AB, W_AB, CLRC_A));
      check("f_busy_b", busy_b, exp_busy(r, DIV_AB, W_AB, CLRC_A));
      check("f_clk_a", led_clk_a, exp_clk(r, DIV_AB, W_AB, CLRC_A));
      check("f_clrn_a", led_clr_n_a, !(r >= 1 && r <= CLRC_A));
      if (c == LAT_A) begin
        check("seq_a", obs_a, 16'h5A3C);
        check("seq_b", obs_b, 16'hC3A5);
      end
    end

    // Reset in cycle 30 of a frame: abort with no done pulse.
    next_cycle();
    p_in  = 16'h5A5A;
    start = 1'b1;
    push_ab(p_in, cyc);
    for (int c = 1; c <= 40; c++) begin
      next_cycle();
      start = 1'b0;
      rst   = (c == 30);
      if (c == 31) begin
        q_a.delete();
        q_b.delete();
        dq_a.delete();
        dq_b.delete();
      end
      @(negedge clk);
      check("r_busy_a", busy_a, c <= 30);
      if (c == 31) begin
        check("r_clk_a", led_clk_a, 1);
        check("r_done_a", done_a, 0);
        check("r_do_a", led_do_a, 1);
        check("r_do_b", led_do_b, 0);
        check("r_clrn_a", led_clr_n_a, 1);
      end
    end

    // Minimum frame: WIDTH=2, DIV=1.
    next_cycle();
    p_in_c  = 2'b10;
    start_c = 1'b1;
    q_c.push_back(1'b0);
    q_c.push_back(1'b1);
    dq_c.push_back(cyc + LAT_C);
    for (int c = 1; c <= LAT_C + 2; c++) begin
      next_cycle();
      start_c = 1'b0;
      @(negedge clk);
      check("c_clk", led_clk_c, exp_clk(c, 1, 2, CLRC_C));
      check("c_busy", busy_c, exp_busy(c, 1, 2, CLRC_C));
    end

    repeat (4) next_cycle();
    check("end_q_a", q_a.size(), 0);
    check("end_q_b", q_b.size(), 0);
    check("end_q_c", q_c.size(), 0);
    check("end_dq_a", dq_a.size(), 0);
    check("end_dq_b", dq_b.size(), 0);
    check("end_dq_c", dq_c.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/led_p2s_ctrl.md
LED_P2S_CTRL -- requirements
Module: led_p2s_ctrl

Interface
REQ-001 Parameter WIDTH, default 16: frame length in bits; legal range 2..64.
REQ-002 Parameter DIV, default 4: clk cycles per serial-clock half-period; legal value >= 1.
REQ-003 Parameter MSB_FIRST, default 1: 1 shifts p_in[WIDTH-1] first, 0 shifts p_in[0] first.
REQ-004 Parameter DO_INV, default 1: 1 drives led_do as the inverted data bit (active-low LED chain).
REQ-005 Port clk, input, 1: single system clock; all logic SHALL be on the rising edge.
REQ-006 Port rst, input, 1: reset, synchronous and active-high.
REQ-007 Port start, input, 1: frame request, sampled each clk.
REQ-008 Port p_in, input, WIDTH: parallel frame data, captured when start is accepted.
REQ-009 Port busy, output, 1: high while a frame is in progress.
REQ-010 Port done, output, 1: one-cycle pulse on frame completion.
REQ-011 Port led_do, output, 1: serial data to the LED shift-register chain.
REQ-012 Port led_clk, output, 1: serial clock; the chain shifts on its rising edge.
REQ-013 Port led_clr_n, output, 1: active-low chain clear.

Function
REQ-014 States: IDLE, CLR, LO, HI, DONE; encoding SHALL be the shared package enum.
REQ-015 start SHALL be accepted only when busy==0 (IDLE or DONE); otherwise it is ignored, with no queuing.
REQ-016 On acceptance: capture p_in into the shift register, load the bit counter with WIDTH, clear the divider counter, go to CLR (macro on) or LO (macro off).
REQ-017 LO: led_clk=0 for exactly DIV cycles; led_do SHALL present the current bit (inverted if DO_INV) from the first LO cycle, stable through HI.
REQ-018 HI: led_clk=1 for exactly DIV cycles. On the last HI cycle the shift register SHALL advance one bit and the counter SHALL decrement; go to LO if counter>1, else DONE.
REQ-019 DONE: one cycle, done=1, busy=0; return to IDLE, or to CLR/LO if start is accepted in that cycle.
REQ-020 IDLE/DONE outputs: led_clk=1, led_do=DO_INV (logic-0 bit), busy=0.
REQ-021 busy SHALL be 1 in CLR, LO and HI.
REQ-022 Latency with macro off: start accepted in cycle 0, done=1 in cycle 2*DIV*WIDTH+1. With macro on, add DIV cycles.
REQ-023 Counter widths: bit counter $clog2(WIDTH+1); divider counter $clog2(DIV) bits, minimum 1; no wrap other than divider terminal count.

Reset
REQ-024 rst SHALL force IDLE on the next edge from any state, including mid-frame: shift register=0, counters=0, busy=0, done=0, led_clk=1, led_do=DO_INV, led_clr_n=1.
REQ-025 rst and start in the same cycle: rst wins and start is dropped.

Configuration
REQ-026 Macro LED_P2S_CLR_EN defined: the CLR state holds led_clr_n=0 for DIV cycles (led_clk=1) before the first LO of every frame.
REQ-027 Macro LED_P2S_CLR_EN undefined: no CLR state; led_clr_n is tied to 1.

Structure
REQ-028 Package led_p2s_pkg SHALL hold the state enum and the localparams for counter widths.
REQ-029 One sub-module, led_p2s_div, SHALL provide the DIV-cycle phase-terminal-count tick with synchronous clear.

Verification
REQ-030 WIDTH=16, DIV=2, MSB_FIRST=1, DO_INV=1, p_in=16'hA5C3: led_do at the 16 led_clk rises = 0101_1010_0011_1100; done at cycle 65; busy high cycles 1..64.
REQ-031 Same p_in, MSB_FIRST=0, DO_INV=0: led_do sequence = 1100_0011_1010_0101.
REQ-032 start pulsed in cycle 20 of a frame: ignored, frame unchanged; start in the DONE cycle: next frame's LO begins the following cycle.
REQ-033 rst asserted in cycle 30: next cycle IDLE, led_clk=1, busy=0, and no done pulse.
REQ-034 LED_P2S_CLR_EN defined, DIV=3, WIDTH=8: led_clr_n=0 in cycles 1..3; done at cycle 52.
REQ-035 DIV=1, WIDTH=2: led_clk low/high each 1 cycle; done at cycle 5.
